// File: rtl/shapool_pkg.sv
// rtl/shapool_pkg.sv - shared widths, counter helper and job FSM encoding
package shapool_pkg;

  localparam int GLOBAL_BITS_DEF = 64;
  localparam int DAISY_BITS_DEF  = 32;
  // Bit counters are wide enough to hold two daisy words plus margin, and saturate
  localparam int CNT_W           = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } job_state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/spi_rx_shifter.sv
// rtl/spi_rx_shifter.sv - SPI pin synchronizer, edge detect, MSB-first shifter and bit counter
module spi_rx_shifter
  import shapool_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_in,
  input  logic             reset_n_in,
  input  logic             sck_in,
  input  logic             sdi_in,
  input  logic             cs_n_in,
  input  logic             load_en_in,
  input  logic [WIDTH-1:0] load_data_in,
  output logic [WIDTH-1:0] shift_out,
  output logic [CNT_W-1:0] count_out,
  output logic             cs_fall_out,
  output logic             cs_rise_out
);

  // Stage 0 is nearest the pin; stage 2 is the oldest sample
  logic [2:0]       sck_sync_q, sck_sync_d;
  logic [2:0]       sdi_sync_q, sdi_sync_d;
  logic [2:0]       cs_sync_q, cs_sync_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             sck_rise;
  logic             cs_low;

  assign sck_rise    = sck_sync_q[1] & ~sck_sync_q[2];
  assign cs_fall_out = cs_sync_q[2] & ~cs_sync_q[1];
  assign cs_rise_out = ~cs_sync_q[2] & cs_sync_q[1];
  assign cs_low      = ~cs_sync_q[1];
  assign shift_out   = shift_q;
  assign count_out   = count_q;

  // Next synchronizer stages and shifter contents; a parallel load beats a coincident sck edge
  always_comb begin
    sck_sync_d = {sck_sync_q[1:0], sck_in};
    sdi_sync_d = {sdi_sync_q[1:0], sdi_in};
    cs_sync_d  = {cs_sync_q[1:0], cs_n_in};
    shift_d    = shift_q;
    count_d    = count_q;
    if (cs_fall_out) begin
      shift_d = '0;
      count_d = '0;
    end else if (load_en_in) begin
      shift_d = load_data_in;
    end else if (cs_low && sck_rise) begin
      shift_d = {shift_q[WIDTH-2:0], sdi_sync_q[2]};
      count_d = sat_inc(count_q);
    end
  end

  // State registers; chip select idles high out of reset
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      sck_sync_q <= '0;
      sdi_sync_q <= '0;
      cs_sync_q  <= 3'b111;
      shift_q    <= '0;
      count_q    <= '0;
    end else begin
      sck_sync_q <= sck_sync_d;
      sdi_sync_q <= sdi_sync_d;
      cs_sync_q  <= cs_sync_d;
      shift_q    <= shift_d;
      count_q    <= count_d;
    end
  end

endmodule

// File: rtl/spi_job_controller.sv
// rtl/spi_job_controller.sv - two-bus SPI job intake, core start/abort sequencing and result return
module spi_job_controller
  import shapool_pkg::*;
#(
  parameter int GLOBAL_BITS = GLOBAL_BITS_DEF,
  parameter int DAISY_BITS  = DAISY_BITS_DEF
) (
  input  logic                   clk_in,
  input  logic                   reset_n_in,
  input  logic                   sck0_in,
  input  logic                   sdi0_in,
  input  logic                   cs0_n_in,
  input  logic                   sck1_in,
  input  logic                   sdi1_in,
  input  logic                   cs1_n_in,
  output logic                   sdo1_out,
  output logic [GLOBAL_BITS-1:0] global_data_out,
  output logic [DAISY_BITS-1:0]  daisy_data_out,
  output logic                   core_start_out,
  output logic                   core_abort_out,
  input  logic                   core_done_in,
  input  logic                   core_success_in,
  input  logic [DAISY_BITS-1:0]  result_in,
  output logic                   ready_oe_out,
  output logic                   frame_err_out,
  output logic [1:0]             state_out
);

  logic [GLOBAL_BITS-1:0] g_shift;
  logic [CNT_W-1:0]       g_count;
  logic                   g_cs_fall, g_cs_rise;
  logic [DAISY_BITS-1:0]  d_shift;
  logic [CNT_W-1:0]       d_count;
  logic                   unused_d_cs_fall, d_cs_rise;
  logic                   d_load;

  job_state_e             state_q, state_d;
  logic                   gvalid_q, gvalid_d;
  logic                   dvalid_q, dvalid_d;
  logic                   err_q, err_d;
  logic                   ready_q, ready_d;
  logic                   start_q, start_d;
  logic                   abort_q, abort_d;
  logic [GLOBAL_BITS-1:0] gdata_q, gdata_d;
  logic [DAISY_BITS-1:0]  ddata_q, ddata_d;

  spi_rx_shifter #(.WIDTH(GLOBAL_BITS)) u_spi0 (
    .clk_in       (clk_in),
    .reset_n_in   (reset_n_in),
    .sck_in       (sck0_in),
    .sdi_in       (sdi0_in),
    .cs_n_in      (cs0_n_in),
    .load_en_in   (1'b0),
    .load_data_in ('0),
    .shift_out    (g_shift),
    .count_out    (g_count),
    .cs_fall_out  (g_cs_fall),
    .cs_rise_out  (g_cs_rise)
  );

  spi_rx_shifter #(.WIDTH(DAISY_BITS)) u_spi1 (
    .clk_in       (clk_in),
    .reset_n_in   (reset_n_in),
    .sck_in       (sck1_in),
    .sdi_in       (sdi1_in),
    .cs_n_in      (cs1_n_in),
    .load_en_in   (d_load),
    .load_data_in (result_in),
    .shift_out    (d_shift),
    .count_out    (d_count),
    .cs_fall_out  (unused_d_cs_fall),
    .cs_rise_out  (d_cs_rise)
  );

  assign sdo1_out        = d_shift[DAISY_BITS-1];
  assign global_data_out = gdata_q;
  assign daisy_data_out  = ddata_q;
  assign core_start_out  = start_q;
  assign core_abort_out  = abort_q;
  assign ready_oe_out    = ready_q;
  assign frame_err_out   = err_q;
  assign state_out       = state_q;

  // Frame-end validation, then job FSM; a new-job abort overrides anything set earlier this cycle
  always_comb begin
    state_d  = state_q;
    gvalid_d = gvalid_q;
    dvalid_d = dvalid_q;
    err_d    = err_q;
    ready_d  = ready_q;
    gdata_d  = gdata_q;
    ddata_d  = ddata_q;
    start_d  = 1'b0;
    abort_d  = 1'b0;
    d_load   = 1'b0;

    if (g_cs_rise) begin
      if (g_count == CNT_W'(GLOBAL_BITS)) begin
        gvalid_d = 1'b1;
        gdata_d  = g_shift;
        err_d    = 1'b0;
      end else begin
        gvalid_d = 1'b0;
        err_d    = 1'b1;
      end
    end

    if (d_cs_rise) begin
      if ((d_count != '0) && ((32'(d_count) % DAISY_BITS) == 0)) begin
        dvalid_d = 1'b1;
        ddata_d  = d_shift;
      end else begin
        err_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (gvalid_q && dvalid_q) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        start_d = 1'b1;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (g_cs_fall) begin
          abort_d  = 1'b1;
          ready_d  = 1'b0;
          gvalid_d = 1'b0;
          dvalid_d = 1'b0;
          state_d  = ST_IDLE;
        end else if (core_done_in) begin
          state_d = ST_DONE;
          if (core_success_in) begin
            d_load  = 1'b1;
            ready_d = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (g_cs_fall) begin
          ready_d  = 1'b0;
          gvalid_d = 1'b0;
          dvalid_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Controller registers; reset discards everything without signalling the core
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q  <= ST_IDLE;
      gvalid_q <= 1'b0;
      dvalid_q <= 1'b0;
      err_q    <= 1'b0;
      ready_q  <= 1'b0;
      start_q  <= 1'b0;
      abort_q  <= 1'b0;
      gdata_q  <= '0;
      ddata_q  <= '0;
    end else begin
      state_q  <= state_d;
      gvalid_q <= gvalid_d;
      dvalid_q <= dvalid_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
      start_q  <= start_d;
      abort_q  <= abort_d;
      gdata_q  <= gdata_d;
      ddata_q  <= ddata_d;
    end
  end

endmodule

// File: tb/tb_spi_job_controller.sv
// tb/tb_spi_job_controller.sv - randomized bench for spi_job_controller against a frame-level model
module tb_spi_job_controller;

  logic        clk_in = 1'b0;
  logic        reset_n_in;
  logic        sck0_in, sdi0_in, cs0_n_in;
  logic        sck1_in, sdi1_in, cs1_n_in;
  logic        sdo1_out;
  logic [63:0] global_data_out;
  logic [31:0] daisy_data_out;
  logic        core_start_out, core_abort_out;
  logic        core_done_in, core_success_in;
  logic [31:0] result_in;
  logic        ready_oe_out, frame_err_out;
  logic [1:0]  state_out;

  spi_job_controller #(.GLOBAL_BITS(64), .DAISY_BITS(32)) dut (
    .clk_in          (clk_in),
    .reset_n_in      (reset_n_in),
    .sck0_in         (sck0_in),
    .sdi0_in         (sdi0_in),
    .cs0_n_in        (cs0_n_in),
    .sck1_in         (sck1_in),
    .sdi1_in         (sdi1_in),
    .cs1_n_in        (cs1_n_in),
    .sdo1_out        (sdo1_out),
    .global_data_out (global_data_out),
    .daisy_data_out  (daisy_data_out),
    .core_start_out  (core_start_out),
    .core_abort_out  (core_abort_out),
    .core_done_in    (core_done_in),
    .core_success_in (core_success_in),
    .result_in       (result_in),
    .ready_oe_out    (ready_oe_out),
    .frame_err_out   (frame_err_out),
    .state_out       (state_out)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_bad = 0;
  int start_seen = 0;
  int abort_seen = 0;

  always @(negedge clk_in) begin
    if (core_start_out) start_seen++;
    if (core_abort_out) abort_seen++;
  end

  // Frame-level reference model: job state 0 idle, 2 running, 3 done
  int          m_state;
  bit          m_gv, m_dv, m_err, m_ready;
  logic [63:0] m_gdata;
  logic [31:0] m_ddata, m_dreg;
  int          m_starts = 0;
  int          m_aborts = 0;

  task automatic chk_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_gv = 0; m_dv = 0; m_err = 0; m_ready = 0;
    m_gdata = '0; m_ddata = '0; m_dreg = '0;
  endtask

  task automatic model_arm();
    if (m_state == 0 && m_gv && m_dv) begin
      m_state = 2;
      m_starts++;
    end
  endtask

  task automatic model_spi0_begin();
    if (m_state == 2) m_aborts++;
    if (m_state == 2 || m_state == 3) begin
      m_state = 0; m_gv = 0; m_dv = 0; m_ready = 0;
    end
  endtask

  task automatic model_spi0_end(input int n, input logic [127:0] data);
    if (n == 64) begin
      m_gv = 1; m_gdata = data[63:0]; m_err = 0;
    end else begin
      m_gv = 0; m_err = 1;
    end
    model_arm();
  endtask

  task automatic model_spi1_end(input int n, input logic [127:0] data);
    logic [127:0] masked;
    masked = data & ((128'd1 << n) - 128'd1);
    m_dreg = masked[31:0];
    if (n > 0 && n % 32 == 0) begin
      m_dv = 1; m_ddata = masked[31:0];
    end else begin
      m_err = 1;
    end
    model_arm();
  endtask

  task automatic check_all(input string tag);
    chk_eq({tag, ".state"}, state_out, m_state);
    chk_eq({tag, ".gdata"}, global_data_out, m_gdata);
    chk_eq({tag, ".ddata"}, daisy_data_out, m_ddata);
    chk_eq({tag, ".err"}, frame_err_out, m_err);
    chk_eq({tag, ".ready"}, ready_oe_out, m_ready);
    chk_eq({tag, ".sdo"}, sdo1_out, m_dreg[31]);
    chk_eq({tag, ".starts"}, start_seen, m_starts);
    chk_eq({tag, ".aborts"}, abort_seen, m_aborts);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic spi0_bits(input int n, input logic [127:0] data);
    for (int i = n - 1; i >= 0; i--) begin
      sdi0_in = (i < 128) ? data[i] : 1'b0;
      cyc(4);
      sck0_in = 1'b1;
      cyc(4);
      sck0_in = 1'b0;
    end
  endtask

  task automatic spi1_bits(input int n, input logic [127:0] data, output logic [127:0] cap);
    cap = '0;
    for (int i = n - 1; i >= 0; i--) begin
      sdi1_in = data[i];
      cyc(4);
      cap = {cap[126:0], sdo1_out};
      sck1_in = 1'b1;
      cyc(4);
      sck1_in = 1'b0;
    end
  endtask

  task automatic spi0_frame(input int n, input logic [127:0] data);
    model_spi0_begin();
    cs0_n_in = 1'b0;
    cyc(4);
    spi0_bits(n, data);
    cyc(2);
    cs0_n_in = 1'b1;
    cyc(8);
    model_spi0_end(n, data);
  endtask

  task automatic spi1_frame(input int n, input logic [127:0] data, output logic [127:0] cap);
    logic [127:0] masked;
    cs1_n_in = 1'b0;
    cyc(4);
    spi1_bits(n, data, cap);
    cyc(2);
    cs1_n_in = 1'b1;
    cyc(8);
    masked = data & ((128'd1 << n) - 128'd1);
    chk_eq("sdo_stream", cap, masked >> 32);
    model_spi1_end(n, data);
  endtask

  task automatic do_core_done(input logic succ, input logic [31:0] res);
    core_done_in    = 1'b1;
    core_success_in = succ;
    result_in       = res;
    cyc(1);
    core_done_in    = 1'b0;
    cyc(3);
    if (m_state == 2) begin
      m_state = 3;
      if (succ) begin
        m_ready = 1;
        m_dreg  = res;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [127:0] cap;
    logic [127:0] rnd;
    int           n, op;

    reset_n_in = 1'b0;
    sck0_in = 0; sdi0_in = 0; cs0_n_in = 1;
    sck1_in = 0; sdi1_in = 0; cs1_n_in = 1;
    core_done_in = 0; core_success_in = 0; result_in = '0;
    model_reset();
    cyc(3);
    check_all("reset");
    reset_n_in = 1'b1;
    cyc(4);

    // Daisy word first, then a short global frame: error, no start
    spi1_frame(32, 128'hDEADBEEF, cap);
    check_all("daisy1");
    do_core_done(1'b1, 32'hFFFF_FFFF);
    check_all("done_idle");
    spi0_frame(63, 128'h0123456789ABCDEF);
    check_all("g63");
    chk_eq("g63_err", frame_err_out, 1'b1);
    spi0_frame(320, {$urandom, $urandom, $urandom, $urandom});
    check_all("g320_sat");

    // Full job: both words valid, one start, running
    spi0_frame(64, 128'h0123456789ABCDEF);
    check_all("job1");
    chk_eq("job1_gdata", global_data_out, 64'h0123456789ABCDEF);
    chk_eq("job1_ddata", daisy_data_out, 32'hDEADBEEF);
    chk_eq("job1_state", state_out, 2'd2);
    chk_eq("job1_start", start_seen, 1);

    // Successful completion; read result back over SPI1
    cs1_n_in = 1'b0;
    m_dreg = '0;
    cyc(4);
    do_core_done(1'b1, 32'h0000_1234);
    check_all("result_load");
    rnd = {96'd0, $urandom};
    spi1_bits(32, rnd, cap);
    chk_eq("result_read", cap, 128'h1234);
    cyc(2);
    cs1_n_in = 1'b1;
    cyc(8);
    model_spi1_end(32, rnd);
    check_all("result_frame");

    // New job from DONE (no abort), then re-arm
    spi0_frame(64, {$urandom, $urandom, $urandom, $urandom});
    check_all("job2_g");
    spi1_frame(32, {96'd0, $urandom}, cap);
    check_all("job2_run");

    // cs0 falls in the same cycle as core_done: abort wins
    model_spi0_begin();
    cs0_n_in = 1'b0;
    cyc(2);
    core_done_in = 1'b1; core_success_in = 1'b1; result_in = 32'hCAFE_F00D;
    cyc(1);
    core_done_in = 1'b0;
    cyc(3);
    check_all("abort_race");
    chk_eq("abort_race_ready", ready_oe_out, 1'b0);
    rnd = {$urandom, $urandom, $urandom, $urandom};
    spi0_bits(64, rnd);
    cyc(2);
    cs0_n_in = 1'b1;
    cyc(8);
    model_spi0_end(64, rnd);
    check_all("job3_g");

    // Two daisy words: first passes through on sdo, second is kept
    spi1_frame(64, 128'hAAAAAAAA_55555555, cap);
    chk_eq("pass_through", cap, 128'hAAAAAAAA);
    check_all("job3_run");

    // Asynchronous reset while running: no clock edge needed, no abort
    #2 reset_n_in = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    cyc(2);
    reset_n_in = 1'b1;
    cyc(4);

    // Randomized frames and core completions
    for (int k = 0; k < 25; k++) begin
      op  = $urandom_range(0, 2);
      rnd = {$urandom, $urandom, $urandom, $urandom};
      if (op == 0) begin
        n = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 70) : 64;
        spi0_frame(n, rnd);
        check_all($sformatf("rnd%0d_spi0_n%0d", k, n));
      end else if (op == 1) begin
        case ($urandom_range(0, 3))
          0: n = 64;
          1: n = $urandom_range(0, 70);
          default: n = 32;
        endcase
        spi1_frame(n, rnd, cap);
        check_all($sformatf("rnd%0d_spi1_n%0d", k, n));
      end else begin
        do_core_done(1'($urandom_range(0, 1)), rnd[31:0]);
        check_all($sformatf("rnd%0d_done", k));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_job_controller.md
SPI_JOB_CONTROLLER -- requirements
Module: spi_job_controller

Interface
REQ-001 SHALL have parameter GLOBAL_BITS, default 64: width of the global job word received on SPI0.
REQ-002 SHALL have parameter DAISY_BITS, default 32: width of the per-device daisy word on SPI1 and of the result.
REQ-003 SHALL have ports clk_in input 1 (single clock) and reset_n_in input 1 (reset, asynchronous, active-low).
REQ-004 SHALL have SPI0 input ports sck0_in, sdi0_in and cs0_n_in, each 1 bit: the global bus, with chip select active-low.
REQ-005 SHALL have SPI1 input ports sck1_in, sdi1_in and cs1_n_in, each 1 bit: the daisy-chain bus, with chip select active-low.
REQ-006 SHALL have sdo1_out output 1: daisy-chain serial out, taken from the MSB of the daisy shift register.
REQ-007 SHALL have global_data_out output GLOBAL_BITS: the committed global word.
REQ-008 SHALL have daisy_data_out output DAISY_BITS: the committed daisy word.
REQ-009 SHALL have core_start_out output 1 and core_abort_out output 1: single-cycle pulses to the core.
REQ-010 SHALL have core_done_in input 1, core_success_in input 1 and result_in input DAISY_BITS: core completion, success flag and result.
REQ-011 SHALL have ready_oe_out output 1: high enables the external open-drain ready line to drive 0.
REQ-012 SHALL have frame_err_out output 1 (sticky framing error) and state_out output 2 (current FSM state).

Function
REQ-013 SHALL pass each of sck0, sdi0, cs0_n, sck1, sdi1 and cs1_n through a 3-flop synchronizer; all logic SHALL use the synchronized values only.
REQ-014 SHALL detect SCK rising edges as (stage2 low, stage1 high), so a shift occurs 3 clk_in cycles after the pin edge.
REQ-015 SHALL, while synced cs0_n is low, shift sdi0 MSB-first into the global shift register and increment a saturating bit counter on each sck0 rising edge.
REQ-016 SHALL clear the bit counter and the shift register contents on the synced cs0_n falling edge.
REQ-017 SHALL treat the synced cs0_n rising edge as the SPI0 frame end: count equal to GLOBAL_BITS sets global_valid and copies the word to global_data_out; any other count sets frame_err_out and clears global_valid.
REQ-018 SHALL shift SPI1 the same way; sdo1_out SHALL present the register MSB, so the daisy word passes through with DAISY_BITS bits of delay.
REQ-019 SHALL treat the synced cs1_n rising edge as the SPI1 frame end: a nonzero count that is a multiple of DAISY_BITS sets daisy_valid and copies the register to daisy_data_out; otherwise it sets frame_err_out.
REQ-020 SHALL implement FSM states IDLE=0, ARMED=1, RUN=2 and DONE=3.
REQ-021 SHALL move IDLE to ARMED when global_valid and daisy_valid are both set.
REQ-022 SHALL, in ARMED, pulse core_start_out for exactly 1 cycle on the next cycle and enter RUN.
REQ-023 SHALL move RUN to DONE on core_done_in; if core_success_in is high, it SHALL load result_in into the daisy shift register and set ready_oe_out.
REQ-024 SHALL, in RUN or DONE, treat a synced cs0_n falling edge as a new job: pulse core_abort_out (RUN only), clear ready_oe_out, global_valid and daisy_valid, and enter IDLE.
REQ-025 SHALL give the abort priority when core_done_in and the cs0_n falling edge occur in the same cycle: no result is loaded and ready_oe_out stays 0.
REQ-026 SHALL ignore core_done_in in IDLE and ARMED.
REQ-027 SHALL, in DONE, allow SPI1 to shift the loaded result out on sdo1_out; a result load and an sck1 edge in the same cycle SHALL resolve as load wins.
REQ-028 SHALL clear frame_err_out only on reset or on a subsequent valid SPI0 frame end.
REQ-029 SHALL saturate the bit counters at their maximum value, with no wrap-around.

Reset
REQ-030 SHALL, on reset_n_in low, asynchronously clear all registers: synchronizers to cs high and sck/sdi low, outputs 0, state IDLE, sdo1_out 0.
REQ-031 SHALL, when reset is asserted mid-frame or in RUN, discard all data without pulsing core_abort_out.

Structure
REQ-032 SHALL keep the state encodings and the default widths in a shared package (shapool_pkg).
REQ-033 SHALL instantiate one sub-module, spi_rx_shifter (synchronizer, edge detect, shift register, counter), twice.

Verification
REQ-034 SHALL include: 64 bits 0x0123456789ABCDEF on SPI0 plus 32 bits 0xDEADBEEF on SPI1 -> global_data_out=0x0123456789ABCDEF, daisy_data_out=0xDEADBEEF, one core_start_out pulse, state RUN.
REQ-035 SHALL include: an SPI0 frame of 63 bits -> frame_err_out=1, global_valid=0, no core_start_out.
REQ-036 SHALL include: in RUN, core_done_in=1 with core_success_in=1 and result_in=0x00001234 -> ready_oe_out=1, and the next 32 sck1 edges read 0x00001234 on sdo1_out.
REQ-037 SHALL include: cs0_n falling in the same cycle as core_done_in -> one core_abort_out pulse, state IDLE, ready_oe_out=0.
REQ-038 SHALL include: 64 bits on SPI1 with 0xAAAAAAAA then 0x55555555 -> sdo1_out emits 0xAAAAAAAA, daisy_data_out=0x55555555.
REQ-039 SHALL include: reset_n_in low while in RUN -> all outputs 0 and state IDLE with no clock edge, no abort pulse.
